// File: rtl/rijndael_shift_rows_pipe.sv
// rijndael_shift_rows_pipe
//   Registered ShiftRows / InvShiftRows stage with a 2-entry elastic buffer.
//   The row rotation is applied as a state is captured, so the buffer holds
//   transformed states. A tag travels alongside each state.
//
// Parameters
//   NB     state columns (4, 6 or 8)
//   TAG_W  sideband tag width
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     upstream state valid
//   in_ready     buffer has a free entry
//   in_inv       0 = ShiftRows, 1 = InvShiftRows for this transaction
//   in_tag       sideband tag
//   in_state     input state, byte k at bits [8k:8k+7], k = 4*col + row
//   out_valid    head entry present
//   out_ready    downstream accepts the head entry
//   out_state    transformed state of the head entry
//   out_tag      tag of the head entry
//   occupancy    entries held (0..2), also serves as the buffer's state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its data stable until ready; the
// buffer never withdraws out_valid or changes out_state/out_tag while
// out_ready is low. in_ready depends only on registered occupancy.
module rijndael_shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [0:32*NB-1]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_state,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  localparam int W = 32 * NB;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : gBadNb
      $error("rijndael_shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  logic [0:W-1] fwdState;
  logic [0:W-1] invState;
  logic [0:W-1] capState;

  // Pure wiring: every source index is a constant worked out at elaboration.
  // Row offsets are 0,1,2,3 except for NB=8, where rows 2 and 3 shift by 3,4.
  for (genvar c = 0; c < NB; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      localparam int OFF  = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int FSRC = 4 * ((c + OFF) % NB) + r;
      localparam int ISRC = 4 * ((c + NB - OFF) % NB) + r;
      assign fwdState[8*(4*c+r) +: 8] = in_state[8*FSRC +: 8];
      assign invState[8*(4*c+r) +: 8] = in_state[8*ISRC +: 8];
    end
  end

  assign capState = in_inv ? invState : fwdState;

  logic [0:W-1]      headState;
  logic [0:W-1]      tailState;
  logic [TAG_W-1:0]  headTag;
  logic [TAG_W-1:0]  tailTag;
  logic [1:0]        occ;
  logic              push;
  logic              pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headState <= '0;
      tailState <= '0;
      headTag   <= '0;
      tailTag   <= '0;
      occ       <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            headState <= capState;
            headTag   <= in_tag;
            occ       <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // Head leaves and is replaced in the same edge; tail stays unused.
            headState <= capState;
            headTag   <= in_tag;
          end else if (push) begin
            tailState <= capState;
            tailTag   <= in_tag;
            occ       <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        2'd2: begin
          // No push possible here: in_ready is low while full.
          if (pop) begin
            headState <= tailState;
            headTag   <= tailTag;
            occ       <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

  assign out_state = headState;
  assign out_tag   = headTag;
  assign occupancy = occ;

endmodule

// File: doc/rijndael_shift_rows_pipe.md
Name: rijndael_shift_rows_pipe

Overview:
Parametrised, registered successor to the combinational ShiftRows stage. It performs the Rijndael row rotation (ShiftRows) or its inverse (InvShiftRows) on a state of NB 32-bit columns, selected per transaction. A 2-entry elastic buffer with valid/ready handshakes sits between it and the neighbouring SubBytes/MixColumns stages of the round pipeline. A tag travels with each state so that key-schedule and round bookkeeping stay aligned.

Parameters:
NB, 4, state columns; legal values 4, 6, 8 (AES = 4); any other value is an elaboration error
TAG_W, 4, width of the sideband tag carried alongside each state (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream state valid
in_ready  out  1  buffer can accept a state
in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows for this transaction
in_tag  in  TAG_W  sideband tag
in_state  in  [0:32*NB-1]  input state; byte k at bits [8k:8k+7]; k = 4*c + r (column-major)
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_state  out  [0:32*NB-1]  transformed state, same byte layout
out_tag  out  TAG_W  tag of the head entry
occupancy  out  2  entries held (0..2)

Behaviour:
- Row offsets C0..C3: 0,1,2,3 for NB=4 and NB=6; 0,1,3,4 for NB=8.
- Forward: out[r][c] = in[r][(c+Cr) mod NB]. Inverse: out[r][(c+Cr) mod NB] = in[r][c]. Index arithmetic is evaluated at elaboration; no runtime modulo hardware.
- Transform is applied combinationally at capture. The stored entry is the transformed state; in_inv is not stored.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (occupancy != 2), registered-derived only. There is no combinational path from out_ready to in_ready.
- out_valid = (occupancy != 0). out_state and out_tag are driven directly from the head register (no output logic).
- Latency: a state pushed at edge N is visible on out_* after edge N when the buffer was empty, i.e. 1 cycle.
- Throughput: 1 state per cycle while out_ready is held high.
- Order is strict FIFO. Entries are head and tail.
  - Push at occupancy 0: write head.
  - Push at occupancy 1 with no pop: write tail.
  - Pop at occupancy 2: tail moves to head.
- Simultaneous push and pop at occupancy 1: head takes the new entry; occupancy stays 1.
- Simultaneous push and pop at occupancy 2 cannot occur, because in_ready=0.
- Pop at occupancy 0 cannot occur, because out_valid=0. out_ready is ignored when empty.
- Input signals are don't-care while in_valid=0. While out_valid=1 && out_ready=0, out_state and out_tag must hold stable.
- Reset (asynchronous assert, synchronous-safe deassert handled upstream): occupancy=0, out_valid=0, in_ready=1, out_state=0, out_tag=0, head and tail data cleared.
- Reset mid-operation drops all held entries. The first push after release is treated as occupancy 0.
- Target size: 150–250 lines of RTL.

Test Plan:
1. NB=4, fwd: in_state=d42711aee0bf98f1b8b45de51e415230, tag=3 -> one cycle later out_valid=1, out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=3.
2. NB=4, in_inv=1 with in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> out_state=d42711aee0bf98f1b8b45de51e415230. Also check a random fwd then inv round trip returns the original over 1000 vectors.
3. NB=8, fwd, in_state bytes 00..1f ascending -> out column 0 = 00 05 0e 13, column 7 = 1c 01 0a 0f. Then NB=6 with the same pattern checked against the offset 1,2,3 model.
4. Backpressure: out_ready=0, push 3 states back-to-back -> 2 accepted, occupancy=2, in_ready=0 on the third. Raise out_ready -> outputs appear in push order, held stable while stalled.
5. Streaming: in_valid=out_ready=1 for 16 cycles with alternating in_inv -> 16 outputs on consecutive cycles, occupancy stays 1, tags in order.
6. Assert rst_n low with occupancy=2 mid-cycle -> out_valid=0, occupancy=0, in_ready=1 immediately (async). After release, a new push emerges with 1-cycle latency and no stale data.
